// File: rtl/vga_fb_display.sv
// vga_fb_display: VGA timing, per-line framebuffer prefetch and scaled RGB332 pixel output.
// Ports: clk pixel clock; res sync active-low reset; hires 128x64 vs 64x32 mode (sampled at frame start);
// fg/bg/border_color RGB332 colours; hSync/vSync sync outputs; vOutside high off window lines;
// frame_tick frame start pulse; r/g/b colour; fbAddr/fbData framebuffer read port (one cycle latency).
module vga_fb_display #(
  parameter int H_FRONT = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_FRONT = 11,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 31,
  parameter int V_ACTIVE = 480,
  parameter int WIN_TOP = 80,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        res,
  input  logic        hires,
  input  logic [7:0]  fg_color,
  input  logic [7:0]  bg_color,
  input  logic [7:0]  border_color,
  output logic        hSync,
  output logic        vSync,
  output logic        vOutside,
  output logic        frame_tick,
  output logic [2:0]  r,
  output logic [2:0]  g,
  output logic [1:0]  b,
  output logic [8:0]  fbAddr,
  input  logic [15:0] fbData
);
  localparam int HD = H_FRONT + H_SYNC + H_BACK;
  localparam int HT = HD + H_ACTIVE;
  localparam int VD = V_FRONT + V_SYNC + V_BACK;
  localparam int VT = VD + V_ACTIVE;
  localparam int WS = VD + WIN_TOP;
  localparam int WE = WS + 320;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;
  logic [11:0] h_q, h_d, v_q, v_d, v_nxt;
  logic        h_end, win, win_nxt, vis, fetch, pix, mode_q;
  logic [0:0]  state_q, state_d;
  logic [3:0]  k_q, k_d, lim, nw, ysub_q, ysub_d, xsub_q, xsub_d;
  logic [5:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [8:0]  addr_q, base;
  logic [15:0] lb_q [8];
  logic        hs_q, vs_q, vo_q, tick_q;
  logic [7:0]  rgb_q, rgb_d;
  always_comb begin
    h_end   = h_q == 12'(HT - 1);
    v_nxt   = (v_q == 12'(VT - 1)) ? '0 : v_q + 12'd1;
    h_d     = h_end ? '0 : h_q + 12'd1;
    v_d     = h_end ? v_nxt : v_q;
    win     = v_q >= 12'(WS) && v_q < 12'(WE);
    win_nxt = v_nxt >= 12'(WS) && v_nxt < 12'(WE);
    vis     = h_q >= 12'(HD) && v_q >= 12'(VD);
    lim     = mode_q ? 4'd4 : 4'd9;
    nw      = mode_q ? 4'd8 : 4'd4;
    // scale counters: sub-counter counts 0..lim, source index advances on its wrap
    ysub_d  = !h_end ? ysub_q : (v_nxt == 12'(WS) || ysub_q == lim) ? '0 : ysub_q + 4'd1;
    row_d   = !h_end ? row_q : v_nxt == 12'(WS) ? '0 : ysub_q == lim ? row_q + 6'd1 : row_q;
    xsub_d  = (h_q == 12'(HD - 1) || xsub_q == lim) ? '0 : xsub_q + 4'd1;
    col_d   = h_q == 12'(HD - 1) ? '0 : xsub_q == lim ? col_q + 7'd1 : col_q;
    fetch   = state_q == FETCH;
    // FETCH spans hPos 0..W: addresses on 0..W-1, data captured on 1..W
    state_d = fetch ? (k_q == nw ? IDLE : FETCH) : (h_end && win_nxt ? FETCH : IDLE);
    k_d     = fetch ? k_q + 4'd1 : '0;
    base    = mode_q ? {row_q, 3'b000} : {1'b0, row_q, 2'b00};
    fbAddr  = (fetch && k_q < nw) ? base + 9'(k_q) : addr_q;
    pix     = lb_q[col_q[6:4]][~col_q[3:0]];
    rgb_d   = !vis ? '0 : !win ? border_color : pix ? fg_color : bg_color;
  end
  always_ff @(posedge clk) begin
    if (!res) begin
      h_q     <= '0;
      v_q     <= '0;
      mode_q  <= 1'b0;
      state_q <= IDLE;
      k_q     <= '0;
      ysub_q  <= '0;
      row_q   <= '0;
      xsub_q  <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      for (int i = 0; i < 8; i++) lb_q[i] <= '0;
      hs_q    <= ~H_SYNC_POL;
      vs_q    <= ~V_SYNC_POL;
      vo_q    <= 1'b1;
      tick_q  <= 1'b0;
      rgb_q   <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      if (h_q == '0 && v_q == '0) mode_q <= hires;
      state_q <= state_d;
      k_q     <= k_d;
      ysub_q  <= ysub_d;
      row_q   <= row_d;
      xsub_q  <= xsub_d;
      col_q   <= col_d;
      addr_q  <= fbAddr;
      if (fetch && k_q != '0) lb_q[3'(k_q - 4'd1)] <= fbData;
      hs_q    <= (h_q >= 12'(H_FRONT) && h_q < 12'(H_FRONT + H_SYNC)) ? H_SYNC_POL : ~H_SYNC_POL;
      vs_q    <= (v_q >= 12'(V_FRONT) && v_q < 12'(V_FRONT + V_SYNC)) ? V_SYNC_POL : ~V_SYNC_POL;
      vo_q    <= ~win;
      tick_q  <= h_d == '0 && v_d == '0;
      rgb_q   <= rgb_d;
    end
  end
  assign hSync      = hs_q;
  assign vSync      = vs_q;
  assign vOutside   = vo_q;
  assign frame_tick = tick_q;
  assign r          = rgb_q[7:5];
  assign g          = rgb_q[4:2];
  assign b          = rgb_q[1:0];
endmodule

// File: tb/tb_vga_fb_display.sv
// tb_vga_fb_display: directed self-checking bench for vga_fb_display with shrunk blanking/frame timing.
module tb_vga_fb_display;
  localparam int HT = 650;
  localparam int VT = 23;
  localparam int FT = HT * VT;
  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        hires = 1'b1;
  logic [7:0]  fg_color = 8'hE0;
  logic [7:0]  bg_color = 8'h03;
  logic [7:0]  border_color = 8'h1C;
  logic        hSync, vSync, vOutside, frame_tick;
  logic [2:0]  r, g;
  logic [1:0]  b;
  logic [8:0]  fbAddr;
  logic [15:0] fbData = '0;
  logic [15:0] mem [512];
  int          n_chk = 0;
  int          n_err = 0;
  int          t = 0;
  vga_fb_display #(
    .H_FRONT(2), .H_SYNC(4), .H_BACK(4), .H_ACTIVE(640),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(20), .WIN_TOP(4)
  ) dut (
    .clk(clk), .res(res), .hires(hires), .fg_color(fg_color), .bg_color(bg_color),
    .border_color(border_color), .hSync(hSync), .vSync(vSync), .vOutside(vOutside),
    .frame_tick(frame_tick), .r(r), .g(g), .b(b), .fbAddr(fbAddr), .fbData(fbData)
  );
  always #5 clk = ~clk;
  always @(posedge clk) fbData <= mem[fbAddr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int at(input int f, input int v, input int h);
    return f * FT + v * HT + h;
  endfunction
  task automatic step_to(input int target);
    while (t < target) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask
  task automatic chk_reset();
    chk("rst_hsync", 32'(hSync), 1);
    chk("rst_vsync", 32'(vSync), 1);
    chk("rst_rgb", 32'({r, g, b}), 0);
    chk("rst_vout", 32'(vOutside), 1);
    chk("rst_tick", 32'(frame_tick), 0);
    chk("rst_addr", 32'(fbAddr), 0);
  endtask
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[0] = 16'h8000;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset();
    res = 1'b1;
    t = 0;
    // frame 0, hires
    step_to(at(0, 0, 1) + 1); chk("hs_pre", 32'(hSync), 1);
    step_to(at(0, 0, 2) + 1); chk("hs_first", 32'(hSync), 0);
    step_to(at(0, 0, 5) + 1); chk("hs_last", 32'(hSync), 0);
    step_to(at(0, 0, 6) + 1); chk("hs_post", 32'(hSync), 1);
    step_to(at(0, 0, 20) + 1); chk("vs_l0", 32'(vSync), 1);
    step_to(at(0, 1, 20) + 1); chk("vs_l1", 32'(vSync), 0);
    step_to(at(0, 2, 2) + 1); chk("hs_line2", 32'(hSync), 0);
    step_to(at(0, 2, 20) + 1); chk("vs_l2", 32'(vSync), 1);
    step_to(at(0, 3, 9) + 1); chk("blank_rgb", 32'({r, g, b}), 0);
    step_to(at(0, 3, 10) + 1); chk("border_rgb", 32'({r, g, b}), 32'h1C);
    chk("border_vout", 32'(vOutside), 1);
    step_to(at(0, 6, 649) + 1); chk("border_last", 32'({r, g, b}), 32'h1C);
    step_to(at(0, 7, 0)); chk("hi_addr0", 32'(fbAddr), 0);
    step_to(at(0, 7, 7)); chk("hi_addr7", 32'(fbAddr), 7);
    step_to(at(0, 7, 9)); chk("hi_addr_hold", 32'(fbAddr), 7);
    step_to(at(0, 7, 10) + 1); chk("hi_wx0", 32'({r, g, b}), 32'hE0);
    chk("win_vout", 32'(vOutside), 0);
    step_to(at(0, 7, 14) + 1); chk("hi_wx4", 32'({r, g, b}), 32'hE0);
    step_to(at(0, 7, 15) + 1); chk("hi_wx5", 32'({r, g, b}), 32'h03);
    hires = 1'b0;
    step_to(at(0, 11, 14) + 1); chk("hi_wy4", 32'({r, g, b}), 32'hE0);
    step_to(at(0, 12, 0)); chk("hi_row1_addr", 32'(fbAddr), 8);
    step_to(at(0, 12, 10) + 1); chk("hi_wy5", 32'({r, g, b}), 32'h03);
    step_to(at(0, 17, 0)); chk("hi_row2_addr", 32'(fbAddr), 16);
    step_to(at(1, 0, 0) - 1); chk("tick_before", 32'(frame_tick), 0);
    step_to(at(1, 0, 0)); chk("tick_f1", 32'(frame_tick), 1);
    step_to(at(1, 0, 0) + 1); chk("tick_after", 32'(frame_tick), 0);
    // frame 1, lores
    step_to(at(1, 7, 0)); chk("lo_addr0", 32'(fbAddr), 0);
    step_to(at(1, 7, 3)); chk("lo_addr3", 32'(fbAddr), 3);
    step_to(at(1, 7, 4)); chk("lo_addr_hold", 32'(fbAddr), 3);
    step_to(at(1, 7, 19) + 1); chk("lo_wx9", 32'({r, g, b}), 32'hE0);
    step_to(at(1, 7, 20) + 1); chk("lo_wx10", 32'({r, g, b}), 32'h03);
    hires = 1'b1;
    step_to(at(1, 16, 0)); chk("lo_wy9_addr", 32'(fbAddr), 0);
    step_to(at(1, 17, 0)); chk("lo_row1_addr", 32'(fbAddr), 4);
    step_to(at(1, 17, 3)); chk("lo_row1_addr3", 32'(fbAddr), 7);
    step_to(at(2, 0, 0) - 1); chk("tick_f2_before", 32'(frame_tick), 0);
    step_to(at(2, 0, 0)); chk("tick_f2", 32'(frame_tick), 1);
    // frame 2, hires again
    step_to(at(2, 7, 12) + 1); chk("hi2_wx2", 32'({r, g, b}), 32'hE0);
    step_to(at(2, 7, 15) + 1); chk("hi2_wx5", 32'({r, g, b}), 32'h03);
    step_to(at(2, 17, 3)); chk("hi2_fetch_addr", 32'(fbAddr), 19);
    res = 1'b0;
    @(posedge clk);
    #1;
    chk_reset();
    res = 1'b1;
    t = 0;
    step_to(at(0, 0, 2) + 1); chk("rs_hs", 32'(hSync), 0);
    step_to(at(0, 1, 20) + 1); chk("rs_vs", 32'(vSync), 0);
    step_to(at(0, 7, 0)); chk("rs_addr0", 32'(fbAddr), 0);
    step_to(at(0, 7, 10) + 1); chk("rs_wx0", 32'({r, g, b}), 32'hE0);
    step_to(at(0, 7, 15) + 1); chk("rs_wx5", 32'({r, g, b}), 32'h03);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/vga_fb_display.md
Name: vga_fb_display

Overview:
Parametrised successor to the fixed-timing VGA output block. It contains the sync timing counters, a framebuffer fetch state machine that prefetches each source row into a local line buffer during horizontal blanking, and a pixel pipeline. The pipeline scales lores (64x32) or hires (128x64) Chip-8 framebuffers into a 640x320 window and colours pixels from programmable RGB332 registers. It sits between the framebuffer RAM read port and the VGA pins, on the VGA pixel clock.

Parameters:
H_FRONT, 16, horizontal front porch cycles (line starts with front porch)
H_SYNC, 96, horizontal sync cycles
H_BACK, 48, horizontal back porch cycles
H_ACTIVE, 640, horizontal visible cycles (must equal 640)
V_FRONT, 11, vertical front porch lines
V_SYNC, 2, vertical sync lines
V_BACK, 31, vertical back porch lines
V_ACTIVE, 480, vertical visible lines
WIN_TOP, 80, first visible line (relative to visible start) of the 320-line framebuffer window
H_SYNC_POL, 0, hSync active level
V_SYNC_POL, 0, vSync active level

Ports:
clk  in  1  VGA pixel clock
res  in  1  reset, synchronous, active-low
hires  in  1  1 = 128x64 mode, 0 = 64x32 mode; sampled at frame start only
fg_color  in  8  RGB332 colour for set pixels
bg_color  in  8  RGB332 colour for clear pixels inside the window
border_color  in  8  RGB332 colour for visible area outside the window
hSync  out  1  horizontal sync, polarity H_SYNC_POL
vSync  out  1  vertical sync, polarity V_SYNC_POL
vOutside  out  1  high when the current line is not a window line
frame_tick  out  1  one-cycle pulse at the first cycle of each frame
r  out  3  red
g  out  3  green
b  out  2  blue
fbAddr  out  9  framebuffer word address, row-major; word = row*words_per_row + col
fbData  in  16  framebuffer word, valid one cycle after fbAddr; MSB = leftmost pixel

Behaviour:
- Reset (res=0 at a clk edge):
  - hPos = vPos = 0; fetch FSM to IDLE; line buffer cleared.
  - mode_q = 0.
  - Outputs: hSync/vSync inactive, r/g/b = 0, vOutside = 1, frame_tick = 0, fbAddr = 0.
  - Reset mid-line or mid-fetch aborts everything; no partial state survives.
- Counters:
  - hPos runs 0..HT-1, HT = sum of H_*. vPos increments when hPos wraps and runs 0..VT-1.
  - Sync is active for hPos in [H_FRONT, H_FRONT+H_SYNC) and for vPos in [V_FRONT, V_FRONT+V_SYNC).
  - Visible region: hPos >= HD = H_FRONT+H_SYNC+H_BACK and vPos >= VD (same construction vertically).
- Frame start: at hPos=0, vPos=0, mode_q <= hires and frame_tick pulses. A change of hires mid-frame has no effect until the next frame.
- Window:
  - Window lines are vPos in [VD+WIN_TOP, VD+WIN_TOP+320). wy = vPos-VD-WIN_TOP.
  - Source row = wy/5 (hires) or wy/10 (lores). Use incrementing sub-counters, not dividers.
  - wx = hPos-HD. Source column = wx/5 (hires) or wx/10 (lores).
- Fetch FSM (IDLE -> FETCH -> IDLE):
  - Leaves IDLE at hPos=0 on every window line.
  - FETCH issues fbAddr = row*W + k for k = 0..W-1 on consecutive cycles, with W = 8 (hires) or 4 (lores).
  - Each fbData is captured into line buffer slot k one cycle after its address; the state takes W+1 cycles.
  - Fetch completes within blanking (HD >= 10 guaranteed by parameters) and never overlaps active pixels.
  - fbAddr holds its last value while IDLE.
- Pixel pipeline:
  - One register stage: r/g/b, hSync, vSync and vOutside at cycle n reflect hPos/vPos of cycle n-1.
  - Colour selection:
    - non-visible -> 0
    - visible, not window line -> border_color
    - window line -> fg_color if the line buffer bit is set, else bg_color
  - Colour inputs are sampled each cycle and need no synchronisation.
- vOutside = 1 for every non-window line, including blanking lines.

Test Plan:
- Default params, release reset -> hSync low for hPos 16..111 (seen 1 cycle later), line length 800, frame length 524 lines, frame_tick period 419200 cycles.
- hires=1, fb word 0 = 0x8000, others 0, fg=0xE0, bg=0x03 -> window line 0: r=7, g=0, b=0 for pixels wx 0..4; wx 5 gives r=0, g=0, b=3; lines wy 0..4 identical, wy 5 shows bg.
- hires=0 -> fbAddr sequence 0,1,2,3 at hPos 0..3 of wy 0..9 and 4..7 for wy 10; lores pixel 0 spans wx 0..9.
- Toggle hires mid-frame -> scaling and address stride unchanged until the cycle after the next frame_tick.
- border_color=0x1C -> visible lines VD..VD+79 output g=7; vOutside=1 there; vOutside=0 on window lines.
- Assert res=0 during FETCH on a window line -> next cycle all outputs are at reset values; after release, timing restarts from hPos=0, vPos=0.
